// File: rtl/handshake_fifo.sv
// handshake_fifo
//   Valid/ready FIFO placed in front of operand ports or behind result
//   ports of arithmetic units. It absorbs back-pressure so a stalled
//   consumer does not freeze the producer's pipeline.
//
//   The handshake is registered on both sides:
//   - in_ready depends only on the occupancy counter and rst.
//   - out_valid depends only on the occupancy counter.
//   So no combinational path runs from out_ready to in_ready, or from
//   in_valid to out_valid.
//
// Parameters
//   WIDTH  data width in bits (>= 1)
//   DEPTH  number of entries (>= 1); any integer, not only a power of two
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active high
//   in_valid   producer offers in_data
//   in_ready   FIFO accepts in_data this cycle
//   in_data    write data
//   out_valid  head entry available on out_data
//   out_ready  consumer takes the head entry this cycle
//   out_data   head entry (don't-care while out_valid = 0)
//   count      number of occupied entries
module handshake_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  // A single-entry FIFO still carries 1-bit pointers so that the
  // declarations stay legal. The pointers are then never used to index.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Storage is deliberately not reset, so it can map onto plain RAM.
  logic [WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             full, empty, push, pop;

  assign full  = (count_reg == FULL_CNT);
  assign empty = (count_reg == '0);

  // in_ready is gated by rst so it drops immediately on an asynchronous
  // reset. While full, input is refused even if a pop happens in the same
  // cycle. This keeps out_ready out of the in_ready path.
  assign in_ready  = !full && !rst;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_reg;

  // Pointers wrap explicitly at DEPTH-1, so a non-power-of-two DEPTH
  // behaves the same as a power of two.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push) begin
      wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  generate
    if (DEPTH == 1) begin : g_single
      // One entry: both pointers are always 0, so index it directly.
      always_ff @(posedge clk) begin
        if (push) begin
          mem[0] <= in_data;
        end
      end
      assign out_data = mem[0];
    end else begin : g_multi
      always_ff @(posedge clk) begin
        if (push) begin
          mem[wr_ptr_reg] <= in_data;
        end
      end
      // The head is read asynchronously. A word written at edge N is then
      // on out_data right after edge N, with no extra read stage.
      assign out_data = mem[rd_ptr_reg];
    end
  endgenerate

endmodule

// File: tb/tb_handshake_fifo.sv
// Testbench for handshake_fifo.
//   Three instances:
//     a : WIDTH=32, DEPTH=4  directed scenarios
//     b : WIDTH=32, DEPTH=3  random wrap-around stream of words 0..999
//     c : WIDTH=8,  DEPTH=1  random stream, alternating full/empty
//   A queue per instance models the FIFO contents. Before every rising
//   edge the bench checks in_ready, out_valid, count and the head word
//   against that queue.
module tb_handshake_fifo;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_in_data, a_out_data;
  logic [2:0]  a_count;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_in_data, b_out_data;
  logic [1:0]  b_count;

  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [7:0]  c_in_data, c_out_data;
  logic [0:0]  c_count;

  handshake_fifo #(.WIDTH(32), .DEPTH(4)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .count(a_count)
  );

  handshake_fifo #(.WIDTH(32), .DEPTH(3)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .count(b_count)
  );

  handshake_fifo #(.WIDTH(8), .DEPTH(1)) dut_c (
    .clk(clk), .rst(rst),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .count(c_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference contents (head at index 0) and words popped from each DUT.
  logic [31:0] qa[$], qb[$], qc[$];
  logic [31:0] a_got[$], b_got[$], c_got[$];
  bit a_push, a_pop, b_push, b_pop, c_push, c_pop;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: check all DUTs against the model before the edge, then
  // apply the model's push/pop at the edge. Returns 1 time unit after
  // the rising edge, which is where the stimulus is changed.
  task automatic cycle();
    @(negedge clk);
    check("a_in_ready",  32'(a_in_ready),  32'(!rst && qa.size() != 4));
    check("a_out_valid", 32'(a_out_valid), 32'(qa.size() != 0));
    check("a_count",     32'(a_count),     32'(qa.size()));
    if (qa.size() != 0) check("a_out_data", a_out_data, qa[0]);
    check("b_in_ready",  32'(b_in_ready),  32'(!rst && qb.size() != 3));
    check("b_out_valid", 32'(b_out_valid), 32'(qb.size() != 0));
    check("b_count",     32'(b_count),     32'(qb.size()));
    if (qb.size() != 0) check("b_out_data", b_out_data, qb[0]);
    check("c_in_ready",  32'(c_in_ready),  32'(!rst && qc.size() != 1));
    check("c_out_valid", 32'(c_out_valid), 32'(qc.size() != 0));
    check("c_count",     32'(c_count),     32'(qc.size()));
    if (qc.size() != 0) check("c_out_data", 32'(c_out_data), qc[0]);

    a_push = !rst && a_in_valid && (qa.size() != 4);
    a_pop  = a_out_ready && (qa.size() != 0);
    b_push = !rst && b_in_valid && (qb.size() != 3);
    b_pop  = b_out_ready && (qb.size() != 0);
    c_push = !rst && c_in_valid && (qc.size() != 1);
    c_pop  = c_out_ready && (qc.size() != 0);
    if (a_pop) a_got.push_back(a_out_data);
    if (b_pop) b_got.push_back(b_out_data);
    if (c_pop) c_got.push_back(32'(c_out_data));

    @(posedge clk);
    if (a_pop)  void'(qa.pop_front());
    if (a_push) qa.push_back(a_in_data);
    if (b_pop)  void'(qb.pop_front());
    if (b_push) qb.push_back(b_in_data);
    if (c_pop)  void'(qc.pop_front());
    if (c_push) qc.push_back(32'(c_in_data));
    #1;
  endtask

  initial begin
    int b_word, c_word, cyc;
    rst = 1'b1;
    a_in_valid = 0; a_in_data = 0; a_out_ready = 0;
    b_in_valid = 0; b_in_data = 0; b_out_ready = 0;
    c_in_valid = 0; c_in_data = 0; c_out_ready = 0;
    a_push = 0; a_pop = 0; b_push = 0; b_pop = 0; c_push = 0; c_pop = 0;

    // Reset state, then release.
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(a_in_ready),  32'(0));
    check("rst_out_valid", 32'(a_out_valid), 32'(0));
    check("rst_count",     32'(a_count),     32'(0));
    rst = 1'b0;
    #1;
    check("rel_in_ready",  32'(a_in_ready),  32'(1));
    check("rel_out_valid", 32'(a_out_valid), 32'(0));

    // Single word: push A5 and see it after one edge, then pop it.
    a_in_valid = 1; a_in_data = 32'h0000_00A5;
    cycle();
    a_in_valid = 0;
    check("single_valid", 32'(a_out_valid), 32'(1));
    check("single_data",  a_out_data,       32'h0000_00A5);
    check("single_count", 32'(a_count),     32'(1));
    a_out_ready = 1;
    cycle();
    a_out_ready = 0;
    check("single_pop_count", 32'(a_count),     32'(0));
    check("single_pop_valid", 32'(a_out_valid), 32'(0));

    // Fill, back-pressure with word 5 held, then drain.
    a_got.delete();
    for (int i = 1; i <= 4; i++) begin
      a_in_valid = 1; a_in_data = 32'(i);
      cycle();
    end
    a_in_data = 32'd5;
    check("fill_count",    32'(a_count),    32'(4));
    check("fill_in_ready", 32'(a_in_ready), 32'(0));
    repeat (3) cycle();
    check("held_count", 32'(a_count), 32'(4));
    a_out_ready = 1;
    cycle();
    check("full_pop_count",    32'(a_count),    32'(3));
    check("full_pop_in_ready", 32'(a_in_ready), 32'(1));
    cycle();
    check("push_pop_count", 32'(a_count), 32'(3));
    a_in_valid = 0;
    repeat (4) cycle();
    a_out_ready = 0;
    check("drain_count", 32'(a_count), 32'(0));
    check("drain_len", 32'(a_got.size()), 32'(5));
    for (int i = 0; i < 5 && i < a_got.size(); i++)
      check("drain_order", a_got[i], 32'(i + 1));

    // Throughput: one prime cycle, then one word in and out per cycle.
    a_in_valid = 1; a_in_data = 32'd100;
    cycle();
    a_out_ready = 1;
    for (int k = 1; k <= 20; k++) begin
      a_in_data = 32'(100 + k);
      cycle();
      check("tput_count", 32'(a_count), 32'(1));
      check("tput_data",  a_out_data,   32'(100 + k));
    end
    a_in_valid = 0;
    repeat (2) cycle();
    a_out_ready = 0;

    // Asynchronous reset mid-cycle with two words held.
    a_in_valid = 1; a_in_data = 32'h11;
    cycle();
    a_in_data = 32'h22;
    cycle();
    a_in_valid = 0;
    check("pre_rst_count", 32'(a_count), 32'(2));
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(a_out_valid), 32'(0));
    check("async_rst_ready", 32'(a_in_ready),  32'(0));
    check("async_rst_count", 32'(a_count),     32'(0));
    qa.delete(); qb.delete(); qc.delete();
    cycle();
    rst = 1'b0;
    #1;
    check("rerel_in_ready",  32'(a_in_ready),  32'(1));
    check("rerel_out_valid", 32'(a_out_valid), 32'(0));

    // Random streams: b carries 0..999, c carries 0..199. Each producer
    // holds its word until that word is accepted.
    b_word = 0; c_word = 0; cyc = 0;
    b_push = 0; c_push = 0;
    b_got.delete(); c_got.delete();
    while ((b_got.size() < 1000 || c_got.size() < 200) && cyc < 20000) begin
      if (!(b_in_valid && !b_push)) begin
        b_in_valid = (b_word < 1000) && ($urandom_range(0, 1) == 1);
        b_in_data  = 32'(b_word);
      end
      if (!(c_in_valid && !c_push)) begin
        c_in_valid = (c_word < 200) && ($urandom_range(0, 1) == 1);
        c_in_data  = 8'(c_word);
      end
      b_out_ready = ($urandom_range(0, 1) == 1);
      c_out_ready = ($urandom_range(0, 1) == 1);
      cycle();
      if (b_push) b_word++;
      if (c_push) c_word++;
      cyc++;
    end
    b_in_valid = 0; c_in_valid = 0; b_out_ready = 0; c_out_ready = 0;
    check("b_stream_len", 32'(b_got.size()), 32'(1000));
    check("c_stream_len", 32'(c_got.size()), 32'(200));
    begin
      int bad0;
      bad0 = n_bad;
      for (int i = 0; i < b_got.size() && n_bad == bad0; i++)
        check("b_stream_order", b_got[i], 32'(i));
      for (int i = 0; i < c_got.size() && n_bad == bad0; i++)
        check("c_stream_order", c_got[i], 32'(i % 256));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
